imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: packs a two's-complement immediate into a RISC-V style
// instruction word (I/S/B/U/J layouts) over a 2-stage valid/ready pipeline.
// S1 holds the request plus its range-check verdict; S2 holds the packed word.
// Unencodable requests pass the base word through unmodified with out_err set,
// and a saturating counter tallies how many such words were handed off.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_src,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_cnt,
  input  logic        err_clr
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  logic        s1_valid_q;
  logic [2:0]  s1_src_q;
  logic [31:0] s1_imm_q;
  logic [31:0] s1_base_q;
  logic        s1_err_q;
  logic        s1_err_d;

  logic        s2_valid_q;
  logic [31:0] s2_inst_q;
  logic        s2_err_q;
  logic [31:0] s2_inst_d;

  logic [7:0]  err_cnt_q;
  logic [7:0]  err_cnt_d;

  logic        s1_adv;
  logic        s2_adv;

  // S2 moves whenever it is empty or its word is being taken; S1 moves
  // whenever it is empty or S2 is about to free up.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

  // Range check: the bits above each format's sign bit must be a pure sign
  // extension, and formats that drop low bits require those bits to be zero.
  always_comb begin
    s1_err_d = 1'b0;
    case (in_src)
      SRC_I, SRC_S: s1_err_d = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      SRC_B:        s1_err_d = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      SRC_U:        s1_err_d = |in_imm[11:0];
      SRC_J:        s1_err_d = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      default:      s1_err_d = 1'b1;
    endcase
  end

  // Stage 1 captures the request and its verdict when it is allowed to advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= 3'b000;
      s1_imm_q   <= 32'h0;
      s1_base_q  <= 32'h0;
      s1_err_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_src_q  <= in_src;
        s1_imm_q  <= in_imm;
        s1_base_q <= in_base;
        s1_err_q  <= s1_err_d;
      end
    end
  end

  // Scatter the immediate bits into the format's fields; errors keep the base.
  always_comb begin
    s2_inst_d = s1_base_q;
    if (!s1_err_q) begin
      case (s1_src_q)
        SRC_I:   s2_inst_d = {s1_imm_q[11:0], s1_base_q[19:0]};
        SRC_S:   s2_inst_d = {s1_imm_q[11:5], s1_base_q[24:12], s1_imm_q[4:0], s1_base_q[6:0]};
        SRC_B:   s2_inst_d = {s1_imm_q[12], s1_imm_q[10:5], s1_base_q[24:12],
                              s1_imm_q[4:1], s1_imm_q[11], s1_base_q[6:0]};
        SRC_U:   s2_inst_d = {s1_imm_q[31:12], s1_base_q[11:0]};
        SRC_J:   s2_inst_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                              s1_imm_q[19:12], s1_base_q[11:0]};
        default: s2_inst_d = s1_base_q;
      endcase
    end
  end

  // Stage 2 registers the packed word; it holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_inst_q  <= 32'h0;
      s2_err_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_q <= s2_inst_d;
        s2_err_q  <= s1_err_q;
      end
    end
  end

  // Error tally: clear wins over a coinciding increment, and it sticks at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = 8'h00;
    end else if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
